// File: rtl/bin_to_onehot_pkg.sv
// Shared state encoding and one-hot decode helper for the way decoder.
package bin_to_onehot_pkg;

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   localparam int MAX_W    = 8;
   localparam int MAX_WAYS = 1 << MAX_W;

   // Bits at or above n_ways never set, so out-of-range indices give zero.
   function automatic logic [MAX_WAYS-1:0] decode(
      input logic [MAX_W-1:0] bin,
      input logic             en,
      input int               n_ways
   );
      logic [MAX_WAYS-1:0] oh;
      oh = '0;
      for (int k = 0; k < MAX_WAYS; k++) begin
         oh[k] = en && (k < n_ways) && (bin == MAX_W'(k));
      end
      return oh;
   endfunction

endpackage

// File: rtl/bin_to_onehot_skid.sv
// Generic 2-entry skid register with valid/ready on both sides.
module bin_to_onehot_skid
   import bin_to_onehot_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          busy
);

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] main_q, main_d;
   logic [DW-1:0] skid_q, skid_d;
   logic          in_xfer, out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = ONE;
               main_d  = in_data;
            end
         end
         ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = in_data;
            end else if (in_xfer) begin
               state_d = TWO;
               skid_d  = in_data;
            end else if (out_xfer) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_xfer) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == EMPTY) || (state_q == ONE);
      out_valid = (state_q == ONE) || (state_q == TWO);
      busy      = (state_q != EMPTY);
      out_data  = main_q;
   end

endmodule

// File: rtl/bin_to_onehot_dec.sv
// Registered binary-to-one-hot way decoder behind a 2-entry skid buffer.
// Optional sticky range error flag: define BIN2OH_RANGE_CHECK_EN.
module bin_to_onehot_dec
   import bin_to_onehot_pkg::*;
#(
   parameter int BIN_W  = 2,
   parameter int N_WAYS = 2 ** BIN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [BIN_W-1:0]  in_bin,
   input  logic              in_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_WAYS-1:0] out_onehot,
   output logic [BIN_W-1:0]  out_bin,
   output logic              busy
`ifdef BIN2OH_RANGE_CHECK_EN
   ,
   output logic              err
`endif
);

   logic [N_WAYS-1:0] dec_oh;

   assign dec_oh = N_WAYS'(decode(MAX_W'(in_bin), in_en, N_WAYS));

`ifdef BIN2OH_RANGE_CHECK_EN
   localparam int DW = 1 + BIN_W + N_WAYS;

   logic          bad;
   logic          tag;
   logic          err_q, err_d;
   logic [DW-1:0] in_data, out_data;

   assign bad     = in_en && (int'(in_bin) >= N_WAYS);
   assign in_data = {bad, in_bin, dec_oh};
   assign {tag, out_bin, out_onehot} = out_data;

   // Flag sets on capture; the carried tag keeps it tied to the entry.
   assign err_d = err_q
                | (in_valid && in_ready && bad)
                | (out_valid && tag);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   localparam int DW = BIN_W + N_WAYS;

   logic [DW-1:0] in_data, out_data;

   assign in_data = {in_bin, dec_oh};
   assign {out_bin, out_onehot} = out_data;
`endif

   bin_to_onehot_skid #(
      .DW(DW)
   ) u_skid (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .busy     (busy)
   );

endmodule

// File: doc/bin_to_onehot_dec.md
Name: bin_to_onehot_dec

Overview:
- Registered binary-to-one-hot decoder; the inverse of the cache's one-hot-to-binary way encoder.
- Converts a binary way index, from the replacement policy or the hit encoder, into a one-hot way-select/write-enable vector for the data and tag memories.
- Valid/ready handshake on both sides with a 2-entry skid buffer, so it can sit between pipeline stages without combinational ready paths.

Parameters:
- BIN_W, 2, width of the binary index.
- N_WAYS, 2**BIN_W, number of one-hot output bits. Legal range is 2 to 2**BIN_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input index valid.
- in_ready  output  1  block can accept an input this cycle.
- in_bin  input  BIN_W  binary way index.
- in_en  input  1  0 forces an all-zero one-hot (no way selected, e.g. a miss with no write).
- out_valid  output  1  out_onehot/out_bin hold a valid decode.
- out_ready  input  1  downstream accepts the output.
- out_onehot  output  N_WAYS  decoded one-hot vector.
- out_bin  output  BIN_W  registered copy of the accepted index, for debug and tracing.
- busy  output  1  at least one entry is held (state != EMPTY).

Behaviour:
- Decode rule: out_onehot[k] = in_en && (in_bin == k) for k in 0..N_WAYS-1. An index >= N_WAYS decodes to all zero. At most one bit is ever set.
- Decode happens at capture time. Only registered vectors are stored, and outputs come straight from flops.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Latency is 1 cycle: a transfer in cycle N gives out_valid=1 in cycle N+1 if the buffer was empty.
- Storage is a main register (drives outputs) plus a skid register.
- State machine:
  - EMPTY: in_ready=1, out_valid=0. Input -> ONE.
  - ONE: in_ready=1, out_valid=1.
    - Input and output together -> ONE; main loads the new decode.
    - Input only -> TWO; the skid register loads.
    - Output only -> EMPTY.
  - TWO: in_ready=0, out_valid=1.
    - Output -> ONE; main loads from skid.
    - Input is ignored, since in_ready is 0.
- in_ready is a registered function of state: asserted in EMPTY and ONE.
- Stability: while out_valid && !out_ready, out_onehot and out_bin hold constant.
- Ordering: strict FIFO order across both entries; no reordering and no drops.
- Reset values: state=EMPTY, in_ready=1, out_valid=0, out_onehot=0, out_bin=0, busy=0, skid contents=0.
- Reset mid-operation: any held entries are discarded. The cycle after reset deasserts, the block is in EMPTY and accepts input.
- in_en=0 with a valid input is still a transfer: it occupies an entry and emits a zero vector.

Optional Feature:
- Macro: BIN2OH_RANGE_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - err goes to 1 the cycle after an input transfer with in_en=1 and in_bin >= N_WAYS.
  - err stays set until reset.
  - out_onehot for that entry is still all zero.
- Undefined:
  - No err port and no check logic.
  - Out-of-range indices silently decode to all zero.
- When N_WAYS == 2**BIN_W, err stays constant 0 in either case.

Decomposition:
- Shared package bin_to_onehot_pkg:
  - State encoding localparams EMPTY=2'd0, ONE=2'd1, TWO=2'd2; the encoding 2'd3 is unused and recovers to EMPTY.
  - Function decode(bin, en) returning the one-hot vector.
- One sub-module, bin_to_onehot_skid:
  - Generic 2-entry skid register, parameterised by data width.
  - Carries {out_bin, out_onehot}, plus the err tag when the optional feature is enabled.
- The top level does the decode and instantiates the skid sub-module.

Test Plan:
- Basic: BIN_W=2, out_ready=1; push in_bin=0,1,2,3 with in_en=1 on consecutive cycles.
  - out_onehot is 0001, 0010, 0100, 1000, one cycle later each.
  - in_ready stays 1 throughout.
- Backpressure: out_ready=0; push 2 then 3.
  - After the second push, in_ready=0 and out_onehot holds 0100.
  - Raise out_ready: output 0100 then 1000, and in_ready returns to 1.
- Enable: push in_bin=3 with in_en=0.
  - out_valid=1 with out_onehot=0000 and out_bin=3.
- Non-power-of-2: BIN_W=2, N_WAYS=3, with BIN2OH_RANGE_CHECK_EN defined; push in_bin=3 with in_en=1.
  - out_onehot=000; err rises the next cycle and stays 1 until reset.
- Reset mid-operation: state TWO (two entries held, out_ready=0); assert reset for 1 cycle.
  - Next cycle: out_valid=0, in_ready=1, out_onehot=0, busy=0.
  - A fresh push of 1 yields 0010.
- Random stress: random in_valid/out_ready over 10k cycles, checked against a scoreboard FIFO.
  - Output sequence matches in order.
  - Every output has popcount <= 1.
  - No transfer ever occurs while in_ready=0.
